// File: rtl/ram_arbiter_if.sv
// One requester's access channel into the RAM arbiter: request fields
// flow toward the arbiter; grant and read-return data flow back.
interface ram_arbiter_if;
    logic        request;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  write_select;
    logic        grant;
    logic        read_valid;
    logic [31:0] read_data;

    // Requester side: drives the access, receives grant and read data
    modport master (
        output request,
        output write,
        output address,
        output write_data,
        output write_select,
        input  grant,
        input  read_valid,
        input  read_data
    );

    // Arbiter side: observes the access, returns grant and read data
    modport slave (
        input  request,
        input  write,
        input  address,
        input  write_data,
        input  write_select,
        output grant,
        output read_valid,
        output read_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single RAM port. Master 0 (CPU data side)
// and master 1 (DMA / debug loader) compete each cycle. The winner's access
// drives the RAM combinationally and read data returns one cycle later.
// A bounded-burst round-robin keeps either master from starving the other.
module ram_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  m0,
    ram_arbiter_if.slave  m1,
    output logic          ram_chip_enable,
    output logic          ram_read_enable,
    output logic [31:0]   ram_read_address,
    input  logic [31:0]   ram_read_data,
    output logic          ram_write_enable,
    output logic [31:0]   ram_write_address,
    output logic [3:0]    ram_write_select,
    output logic [31:0]   ram_write_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    state_t      state_reg;
    logic [3:0]  burst_count_reg;
    logic        burst_full;
    logic        win0;
    logic        win1;
    logic        grant0;
    logic        grant1;
    logic        read_valid0_reg;
    logic        read_valid1_reg;
    logic [31:0] read_data0_reg;
    logic [31:0] read_data1_reg;

    assign burst_full = (burst_count_reg == BURST_LIMIT);

    // Winner selection: a lone requester always wins; on a tie the current
    // owner keeps the port until its burst budget is spent, and IDLE favours m0
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (m0.request && m1.request) begin
            unique case (state_reg)
                OWN0:    win0 = ~burst_full;
                OWN1:    win0 = burst_full;
                default: win0 = 1'b1;
            endcase
            win1 = ~win0;
        end else begin
            win0 = m0.request;
            win1 = m1.request;
        end
    end

    // Everything combinational is held low while reset is asserted
    assign grant0          = win0 & reset;
    assign grant1          = win1 & reset;
    assign m0.grant        = grant0;
    assign m1.grant        = grant1;
    assign ram_chip_enable = reset;

    // RAM port drive from the winner; all fields idle at zero with no winner
    always_comb begin
        ram_read_enable   = 1'b0;
        ram_write_enable  = 1'b0;
        ram_read_address  = 32'h0;
        ram_write_address = 32'h0;
        ram_write_select  = 4'h0;
        ram_write_data    = 32'h0;
        if (grant0) begin
            ram_read_enable   = ~m0.write;
            ram_write_enable  = m0.write;
            ram_read_address  = m0.address;
            ram_write_address = m0.address;
            ram_write_select  = m0.write_select;
            ram_write_data    = m0.write_data;
        end else if (grant1) begin
            ram_read_enable   = ~m1.write;
            ram_write_enable  = m1.write;
            ram_read_address  = m1.address;
            ram_write_address = m1.address;
            ram_write_select  = m1.write_select;
            ram_write_data    = m1.write_data;
        end
    end

    // Ownership/burst tracking plus registered read return for both masters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            burst_count_reg <= 4'd0;
            read_valid0_reg <= 1'b0;
            read_valid1_reg <= 1'b0;
            read_data0_reg  <= 32'h0;
            read_data1_reg  <= 32'h0;
        end else begin
            if (grant0) begin
                if (state_reg == OWN0) begin
                    if (!burst_full) begin
                        burst_count_reg <= burst_count_reg + 4'd1;
                    end
                end else begin
                    state_reg       <= OWN0;
                    burst_count_reg <= 4'd1;
                end
            end else if (grant1) begin
                if (state_reg == OWN1) begin
                    if (!burst_full) begin
                        burst_count_reg <= burst_count_reg + 4'd1;
                    end
                end else begin
                    state_reg       <= OWN1;
                    burst_count_reg <= 4'd1;
                end
            end else begin
                state_reg       <= IDLE;
                burst_count_reg <= 4'd0;
            end

            // A read grant captures RAM data; read_data holds until the next read
            read_valid0_reg <= grant0 & ~m0.write;
            read_valid1_reg <= grant1 & ~m1.write;
            if (grant0 && !m0.write) begin
                read_data0_reg <= ram_read_data;
            end
            if (grant1 && !m1.write) begin
                read_data1_reg <= ram_read_data;
            end
        end
    end

    assign m0.read_valid = read_valid0_reg;
    assign m1.read_valid = read_valid1_reg;
    assign m0.read_data  = read_data0_reg;
    assign m1.read_data  = read_data1_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, single read, write/read-back,
// byte-lane write, fairness wrap-around, idle tie-break, lone requester,
// and reset asserted mid-burst. Includes a small behavioural RAM.
module tb_ram_arbiter;

    logic        clock;
    logic        reset;
    logic        ram_chip_enable;
    logic        ram_read_enable;
    logic [31:0] ram_read_address;
    logic [31:0] ram_read_data;
    logic        ram_write_enable;
    logic [31:0] ram_write_address;
    logic [3:0]  ram_write_select;
    logic [31:0] ram_write_data;

    int checks;
    int failures;

    logic [31:0] mem [0:255];

    ram_arbiter_if m0_bus ();
    ram_arbiter_if m1_bus ();

    ram_arbiter #(.MAX_BURST(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .m0                (m0_bus),
        .m1                (m1_bus),
        .ram_chip_enable   (ram_chip_enable),
        .ram_read_enable   (ram_read_enable),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data),
        .ram_write_enable  (ram_write_enable),
        .ram_write_address (ram_write_address),
        .ram_write_select  (ram_write_select),
        .ram_write_data    (ram_write_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: combinational read, byte-laned write at the edge
    assign ram_read_data = mem[ram_read_address[9:2]];
    always @(posedge clock) begin
        if (ram_write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_write_select[b]) begin
                    mem[ram_write_address[9:2]][8*b +: 8] <= ram_write_data[8*b +: 8];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive0(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel);
        m0_bus.request      = req;
        m0_bus.write        = wr;
        m0_bus.address      = addr;
        m0_bus.write_data   = data;
        m0_bus.write_select = sel;
    endtask

    task automatic drive1(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] sel);
        m1_bus.request      = req;
        m1_bus.write        = wr;
        m1_bus.address      = addr;
        m1_bus.write_data   = data;
        m1_bus.write_select = sel;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_m0_valid", 32'(m0_bus.read_valid), 32'h0);
        chk("rst_m1_valid", 32'(m1_bus.read_valid), 32'h0);
        chk("rst_m0_data", m0_bus.read_data, 32'h0);
        chk("rst_m1_data", m1_bus.read_data, 32'h0);
        chk("rst_chip_en", 32'(ram_chip_enable), 32'h0);
        chk("rst_state", 32'(dut.state_reg), 32'h0);
        chk("rst_burst", 32'(dut.burst_count_reg), 32'h0);
        reset = 1'b1;
        settle();
        chk("rel_chip_en", 32'(ram_chip_enable), 32'h1);
        chk("rel_grant0", 32'(m0_bus.grant), 32'h0);

        // ---- Preload 0x10 via m1 write ----
        tick();
        drive1(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        settle();
        chk("pre_m1_grant", 32'(m1_bus.grant), 32'h1);
        tick();
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // ---- Single read by m0 ----
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        settle();
        chk("rd_m0_grant", 32'(m0_bus.grant), 32'h1);
        chk("rd_m1_grant", 32'(m1_bus.grant), 32'h0);
        chk("rd_raddr", ram_read_address, 32'h10);
        chk("rd_ren", 32'(ram_read_enable), 32'h1);
        chk("rd_wen", 32'(ram_write_enable), 32'h0);
        tick();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("rd_m0_valid", 32'(m0_bus.read_valid), 32'h1);
        chk("rd_m0_data", m0_bus.read_data, 32'hDEADBEEF);
        chk("rd_m1_valid", 32'(m1_bus.read_valid), 32'h0);
        tick();
        chk("rd_m0_valid_drop", 32'(m0_bus.read_valid), 32'h0);
        chk("rd_m0_data_hold", m0_bus.read_data, 32'hDEADBEEF);

        // ---- Write then read ----
        drive1(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        settle();
        chk("wr_m1_grant", 32'(m1_bus.grant), 32'h1);
        chk("wr_wen", 32'(ram_write_enable), 32'h1);
        chk("wr_ren", 32'(ram_read_enable), 32'h0);
        chk("wr_waddr", ram_write_address, 32'h20);
        chk("wr_wdata", ram_write_data, 32'h12345678);
        chk("wr_wsel", 32'(ram_write_select), 32'hF);
        tick();
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive0(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("wr_no_m1_valid", 32'(m1_bus.read_valid), 32'h0);
        settle();
        chk("wr_rd_m0_grant", 32'(m0_bus.grant), 32'h1);
        tick();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("wr_rd_m0_valid", 32'(m0_bus.read_valid), 32'h1);
        chk("wr_rd_m0_data", m0_bus.read_data, 32'h12345678);
        chk("wr_rd_m1_valid", 32'(m1_bus.read_valid), 32'h0);

        // ---- Partial byte-lane write, then read back ----
        drive1(1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0011);
        tick();
        drive1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("bl_m1_valid", 32'(m1_bus.read_valid), 32'h1);
        chk("bl_m1_data", m1_bus.read_data, 32'h1234CCDD);
        tick();

        // ---- Fairness: both request reads from IDLE for 16 cycles ----
        chk("fair_start_idle", 32'(dut.state_reg), 32'h0);
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            settle();
            chk($sformatf("fair_g0_%0d", i), 32'(m0_bus.grant), ((i / 4) % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("fair_g1_%0d", i), 32'(m1_bus.grant), ((i / 4) % 2 == 1) ? 32'h1 : 32'h0);
            tick();
        end
        // The last grant (cycle 15) went to m1, so m1 returns data now
        chk("fair_m1_valid", 32'(m1_bus.read_valid), 32'h1);
        chk("fair_m1_data", m1_bus.read_data, 32'h1234CCDD);
        chk("fair_m0_valid", 32'(m0_bus.read_valid), 32'h0);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // ---- Idle tie-break ----
        drive1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("tie_m1_grant_%0d", i), 32'(m1_bus.grant), 32'h1);
            tick();
        end
        chk("tie_own1", 32'(dut.state_reg), 32'h2);
        chk("tie_burst2", 32'(dut.burst_count_reg), 32'h2);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        chk("tie_idle", 32'(dut.state_reg), 32'h0);
        drive0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        settle();
        chk("tie_m0_grant", 32'(m0_bus.grant), 32'h1);
        chk("tie_m1_grant", 32'(m1_bus.grant), 32'h0);
        tick();
        chk("tie_own0", 32'(dut.state_reg), 32'h1);
        chk("tie_burst1", 32'(dut.burst_count_reg), 32'h1);
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // ---- Lone requester: m1 alone for 10 cycles ----
        drive1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("solo_grant_%0d", i), 32'(m1_bus.grant), 32'h1);
            tick();
            chk($sformatf("solo_burst_%0d", i), 32'(dut.burst_count_reg), (i < 3) ? 32'(i + 1) : 32'h4);
            chk($sformatf("solo_valid_%0d", i), 32'(m1_bus.read_valid), 32'h1);
        end
        chk("solo_data", m1_bus.read_data, 32'hDEADBEEF);

        // ---- Reset asserted mid-burst (m1 still reading) ----
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_m1_valid", 32'(m1_bus.read_valid), 32'h0);
        chk("mrst_m1_data", m1_bus.read_data, 32'h0);
        chk("mrst_m1_grant", 32'(m1_bus.grant), 32'h0);
        chk("mrst_chip_en", 32'(ram_chip_enable), 32'h0);
        chk("mrst_ren", 32'(ram_read_enable), 32'h0);
        chk("mrst_raddr", ram_read_address, 32'h0);
        chk("mrst_state", 32'(dut.state_reg), 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_m0_valid", 32'(m0_bus.read_valid), 32'h0);
        chk("post_m1_valid", 32'(m1_bus.read_valid), 32'h0);
        chk("post_grant0", 32'(m0_bus.grant), 32'h0);
        chk("post_grant1", 32'(m1_bus.grant), 32'h0);
        chk("post_ren", 32'(ram_read_enable), 32'h0);
        chk("post_wen", 32'(ram_write_enable), 32'h0);
        chk("post_chip_en", 32'(ram_chip_enable), 32'h1);
        chk("post_state", 32'(dut.state_reg), 32'h0);
        tick();
        chk("post2_m1_valid", 32'(m1_bus.read_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
